// File: rtl/sample_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sample_sequencer: per-period ADC -> processor -> DAC sample sequencer     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module sample_sequencer #(
  parameter int DW         = 10,
  parameter int PW         = 16,
  parameter int TIMEOUT    = 1023,
  parameter int MIN_PERIOD = 63
) (
  input  logic          sysclk,
  input  logic          reset,
  input  logic          enable,
  input  logic [PW-1:0] period,
  output logic          adc_start,
  input  logic          adc_valid,
  input  logic [DW-1:0] adc_data,
  output logic [DW-1:0] proc_din,
  output logic          proc_din_valid,
  input  logic          proc_dout_valid,
  input  logic [DW-1:0] proc_dout,
  output logic [DW-1:0] dac_data,
  output logic          dac_load,
  output logic          busy,
  output logic [7:0]    overrun_cnt,
  output logic          timeout_flag
);

  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT - 1);
  localparam logic [PW-1:0] P_MIN   = PW'(MIN_PERIOD);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ADC_WAIT  = 2'd1,
    PROC_WAIT = 2'd2,
    DAC_LOAD  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] per_q, per_d;
  logic [PW-1:0] per_eff;
  logic          tick;
  logic [WW-1:0] wdog_q, wdog_d;
  logic [DW-1:0] proc_din_q, proc_din_d;
  logic [DW-1:0] dac_data_q, dac_data_d;
  logic          adc_start_q, adc_start_d;
  logic          proc_din_valid_q, proc_din_valid_d;
  logic          dac_load_q, dac_load_d;
  logic [7:0]    ovr_q, ovr_d;
  logic          timeout_q, timeout_d;

  // Free-running tick counter; the period is latched only at wrap.
  always_comb begin
    per_eff = (period < P_MIN) ? P_MIN : period;
    tick    = (cnt_q == per_q);
    cnt_d   = tick ? '0 : cnt_q + PW'(1);
    per_d   = tick ? per_eff : per_q;
  end

  always_comb begin
    state_d          = state_q;
    wdog_d           = wdog_q;
    proc_din_d       = proc_din_q;
    dac_data_d       = dac_data_q;
    adc_start_d      = 1'b0;
    proc_din_valid_d = 1'b0;
    dac_load_d       = 1'b0;
    timeout_d        = timeout_q;
    ovr_d            = ovr_q;

    if (tick && enable && (state_q != IDLE) && (ovr_q != 8'hFF))
      ovr_d = ovr_q + 8'd1;

    case (state_q)
      IDLE: begin
        if (tick && enable) begin
          adc_start_d = 1'b1;
          wdog_d      = '0;
          state_d     = ADC_WAIT;
        end
      end
      ADC_WAIT: begin
        if (adc_valid) begin
          proc_din_d       = adc_data;
          proc_din_valid_d = 1'b1;
          wdog_d           = '0;
          state_d          = PROC_WAIT;
        end else if (wdog_q == WD_LAST) begin
          timeout_d = 1'b1;
          state_d   = IDLE;
        end else begin
          wdog_d = wdog_q + WW'(1);
        end
      end
      PROC_WAIT: begin
        if (proc_dout_valid) begin
          dac_data_d = proc_dout;
          state_d    = DAC_LOAD;
        end else if (wdog_q == WD_LAST) begin
          timeout_d = 1'b1;
          state_d   = IDLE;
        end else begin
          wdog_d = wdog_q + WW'(1);
        end
      end
      DAC_LOAD: begin
        // dac_data settled last cycle; the load strobe follows one cycle later.
        dac_load_d = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      state_q          <= IDLE;
      cnt_q            <= '0;
      per_q            <= per_eff;
      wdog_q           <= '0;
      proc_din_q       <= '0;
      dac_data_q       <= '0;
      adc_start_q      <= 1'b0;
      proc_din_valid_q <= 1'b0;
      dac_load_q       <= 1'b0;
      ovr_q            <= 8'd0;
      timeout_q        <= 1'b0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      per_q            <= per_d;
      wdog_q           <= wdog_d;
      proc_din_q       <= proc_din_d;
      dac_data_q       <= dac_data_d;
      adc_start_q      <= adc_start_d;
      proc_din_valid_q <= proc_din_valid_d;
      dac_load_q       <= dac_load_d;
      ovr_q            <= ovr_d;
      timeout_q        <= timeout_d;
    end
  end

  assign adc_start      = adc_start_q;
  assign proc_din       = proc_din_q;
  assign proc_din_valid = proc_din_valid_q;
  assign dac_data       = dac_data_q;
  assign dac_load       = dac_load_q;
  assign busy           = (state_q != IDLE);
  assign overrun_cnt    = ovr_q;
  assign timeout_flag   = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_sample_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_sample_sequencer: directed scoreboard bench for sample_sequencer       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_sample_sequencer;

  logic        sysclk = 1'b0;
  logic        reset  = 1'b1;
  logic        enable = 1'b0;
  logic [15:0] period = 16'd999;
  logic        adc_start;
  logic        adc_valid = 1'b0;
  logic [9:0]  adc_data  = 10'd0;
  logic [9:0]  proc_din;
  logic        proc_din_valid;
  logic        proc_dout_valid = 1'b0;
  logic [9:0]  proc_dout = 10'd0;
  logic [9:0]  dac_data;
  logic        dac_load;
  logic        busy;
  logic [7:0]  overrun_cnt;
  logic        timeout_flag;

  sample_sequencer dut (
    .sysclk(sysclk), .reset(reset), .enable(enable), .period(period),
    .adc_start(adc_start), .adc_valid(adc_valid), .adc_data(adc_data),
    .proc_din(proc_din), .proc_din_valid(proc_din_valid),
    .proc_dout_valid(proc_dout_valid), .proc_dout(proc_dout),
    .dac_data(dac_data), .dac_load(dac_load), .busy(busy),
    .overrun_cnt(overrun_cnt), .timeout_flag(timeout_flag)
  );

  always #5 sysclk = ~sysclk;

  int cyc = 0;
  always @(posedge sysclk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Models and scoreboard state
  int         adc_lat  = 900;
  int         proc_lat = 5;
  logic [9:0] mask     = 10'h155;
  logic [9:0] next_adc = 10'h0F3;
  int         adc_cd   = 0;
  int         p_cd     = 0;
  logic [9:0] p_hold   = 10'd0;
  int         v_time   = 0;
  int         q_time   = 0;
  logic [9:0] din_q[$];
  logic [9:0] exp_q[$];
  int         n_loads  = 0;
  int         n_pdv    = 0;
  int         last_start = -1;
  int         chk_period = 0;
  logic       prev_to    = 1'b0;

  // ADC: answers adc_lat cycles after adc_start (never if adc_lat <= 0)
  always @(negedge sysclk) begin
    adc_valid = 1'b0;
    if (adc_start === 1'b1 && adc_lat > 0) adc_cd = adc_lat;
    else if (adc_cd > 0) begin
      adc_cd--;
      if (adc_cd == 0) begin
        adc_valid = 1'b1;
        adc_data  = next_adc;
        v_time    = cyc;
        din_q.push_back(next_adc);
        exp_q.push_back(next_adc ^ mask);
        next_adc  = 10'($urandom);
      end
    end
  end

  // Processor: returns proc_din ^ mask, proc_lat cycles after proc_din_valid
  always @(negedge sysclk) begin
    proc_dout_valid = 1'b0;
    if (proc_din_valid === 1'b1) begin
      p_cd   = proc_lat;
      p_hold = proc_din;
    end else if (p_cd > 0) begin
      p_cd--;
      if (p_cd == 0) begin
        proc_dout_valid = 1'b1;
        proc_dout       = p_hold ^ mask;
        q_time          = cyc;
      end
    end
  end

  // Output monitor
  always @(negedge sysclk) begin
    if (adc_start === 1'b1) begin
      if (chk_period > 0 && last_start >= 0) chk("tick_period", cyc - last_start, chk_period);
      last_start = cyc;
    end
    if (proc_din_valid === 1'b1) begin
      n_pdv++;
      chk("din_q_size", din_q.size(), 1);
      if (din_q.size() > 0) chk("proc_din", proc_din, din_q.pop_front());
      chk("adc_to_din_lat", cyc - v_time, 1);
    end
    if (dac_load === 1'b1) begin
      n_loads++;
      chk("exp_q_size", exp_q.size(), 1);
      if (exp_q.size() > 0) chk("dac_data", dac_data, exp_q.pop_front());
      chk("proc_to_load_lat", cyc - q_time, 2);
    end
    if (timeout_flag === 1'b1 && prev_to === 1'b0)
      chk("timeout_lat", cyc - last_start, 1023);
    prev_to = timeout_flag;
  end

  task automatic check_reset_state(input string tag);
    chk({tag, "_adc_start"}, adc_start, 0);
    chk({tag, "_proc_din"}, proc_din, 0);
    chk({tag, "_proc_din_valid"}, proc_din_valid, 0);
    chk({tag, "_dac_data"}, dac_data, 0);
    chk({tag, "_dac_load"}, dac_load, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_overrun"}, overrun_cnt, 0);
    chk({tag, "_timeout"}, timeout_flag, 0);
  endtask

  task automatic wait_loads(input int target, input int budget, input string tag);
    for (int i = 0; i < budget; i++) begin
      if (n_loads >= target) break;
      @(negedge sysclk);
    end
    chk(tag, n_loads >= target, 1);
  endtask

  task automatic pulse_reset;
    reset = 1'b1;
    repeat (3) @(negedge sysclk);
    reset = 1'b0;
    din_q.delete();
    exp_q.delete();
    adc_cd     = 0;
    last_start = -1;
  endtask

  initial begin
    int saved_loads;
    logic [9:0] saved_dac;

    // Reset values
    repeat (3) @(negedge sysclk);
    check_reset_state("reset");
    reset = 1'b0;

    // Nominal 1000-cycle period, ADC 900 cycles, processor 5 cycles
    enable     = 1'b1;
    chk_period = 1000;
    wait_loads(3, 5000, "nominal_loads");
    chk("nominal_overrun", overrun_cnt, 0);
    chk("nominal_timeout", timeout_flag, 0);

    // Known sample, processor echo after 3 cycles
    mask     = 10'h000;
    proc_lat = 3;
    next_adc = 10'h2A5;
    wait_loads(4, 1500, "echo_load");
    chk("echo_dac_data", dac_data, 10'h2A5);

    // ADC never answers: watchdog abort
    adc_lat     = 0;
    chk_period  = 0;
    saved_loads = n_loads;
    saved_dac   = dac_data;
    for (int i = 0; i < 3000; i++) begin
      if (timeout_flag === 1'b1) break;
      @(negedge sysclk);
    end
    chk("timeout_seen", timeout_flag, 1);
    chk("timeout_idle", busy, 0);
    repeat (20) @(negedge sysclk);
    chk("timeout_no_load", n_loads, saved_loads);
    chk("timeout_dac_kept", dac_data, saved_dac);
    chk("timeout_overrun", overrun_cnt, 1);

    // Overrun counting with a 100-cycle period and a 900-cycle ADC
    period  = 16'd99;
    adc_lat = 900;
    proc_lat = 5;
    pulse_reset();
    chk("rst2_timeout_clear", timeout_flag, 0);
    saved_loads = n_loads;
    wait_loads(saved_loads + 1, 1500, "ovr_load1");
    chk("ovr_after_1", overrun_cnt, 9);
    wait_loads(saved_loads + 2, 1500, "ovr_load2");
    chk("ovr_after_2", overrun_cnt, 18);
    wait_loads(saved_loads + 30, 30000, "ovr_load30");
    chk("ovr_saturated", overrun_cnt, 255);
    chk("ovr_no_timeout", timeout_flag, 0);

    // Period below the clamp: effective 64-cycle period
    period  = 16'd10;
    adc_lat = 20;
    saved_loads = n_loads;
    wait_loads(saved_loads + 3, 5000, "clamp_settle");
    last_start = -1;
    chk_period = 64;
    wait_loads(saved_loads + 7, 1000, "clamp_loads");
    chk("clamp_ovr_held", overrun_cnt, 255);

    // Reset while waiting on the processor
    chk_period = 0;
    proc_lat   = 200;
    saved_loads = n_pdv;
    for (int i = 0; i < 200; i++) begin
      if (n_pdv > saved_loads) break;
      @(negedge sysclk);
    end
    chk("proc_wait_entered", n_pdv > saved_loads, 1);
    repeat (10) @(negedge sysclk);
    chk("busy_before_reset", busy, 1);
    reset = 1'b1;
    @(negedge sysclk);
    check_reset_state("midreset");
    reset  = 1'b0;
    enable = 1'b0;
    din_q.delete();
    exp_q.delete();
    saved_loads = n_loads;
    repeat (300) @(negedge sysclk);
    chk("late_valid_no_load", n_loads, saved_loads);
    chk("disabled_no_overrun", overrun_cnt, 0);
    chk("disabled_idle", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
